// File: rtl/wb_pkg.sv
// Shared WishBone definitions for the SRAM slave.
// Bus widths, FSM state encoding and lane mask helper.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WB_ADR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  function automatic logic [WB_DATA_W-1:0] sel_mask(
    input logic [WB_SEL_W-1:0] sel
  );
    logic [WB_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < WB_SEL_W; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_sram_array.sv
// Word-organised SRAM with byte write enables.
// Read port is registered; contents are never reset.
module wb_sram_array
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [WB_SEL_W-1:0]   wr_be,
  input  logic [WB_DATA_W-1:0]  wr_data,
  output logic [WB_DATA_W-1:0]  rd_data
);

  logic [WB_DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (wr_be[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/wishbone_sram_slave.sv
// WishBone classic-cycle SRAM slave with wait states.
// Decodes window/alignment, responds with ack or err.
module wishbone_sram_slave
  import wb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [WB_ADR_W-1:0]  adr_i,
  input  logic [WB_SEL_W-1:0]  sel_i,
  input  logic [WB_DATA_W-1:0] dat_i,
  output logic [WB_DATA_W-1:0] dat_o,
  output logic                 ack_o,
  output logic                 err_o
);

  localparam logic [WB_ADR_W-1:0] WIN_MASK =
    (32'd1 << (ADDR_WIDTH + 2)) - 32'd1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("WAIT_STATES must be within 0..15");
  end

  if ((BASE_ADDR & WIN_MASK) != 32'd0) begin : g_base_chk
    $error("BASE_ADDR not aligned to window size");
  end

  wb_state_e state;
  logic [3:0] cnt;

  logic                  we_q;
  logic                  ok_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [WB_DATA_W-1:0]  dat_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  logic                  req;
  logic                  dec_ok;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [WB_SEL_W-1:0]   wr_be;
  logic [WB_DATA_W-1:0]  rd_data;

  assign req = cyc_i & stb_i;

  assign dec_ok = (adr_i[1:0] == 2'b00)
    && ((adr_i & ~WIN_MASK) == (BASE_ADDR & ~WIN_MASK))
    && (sel_i != '0);

  // Zero-wait reads must fetch straight from the bus address.
  assign rd_idx = (state == ST_IDLE)
    ? adr_i[ADDR_WIDTH+1:2] : idx_q;

  assign wr_be = (state == ST_RESP && ok_q && we_q)
    ? sel_q : '0;

  wb_sram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .rd_idx (rd_idx),
    .wr_idx (idx_q),
    .wr_be  (wr_be),
    .wr_data(dat_q),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      we_q  <= 1'b0;
      ok_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      idx_q <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            we_q  <= we_i;
            ok_q  <= dec_ok;
            sel_q <= sel_i;
            dat_q <= dat_i;
            idx_q <= adr_i[ADDR_WIDTH+1:2];
            cnt   <= WS;
            if (WS != 4'd0) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_RESP;
              ack_o <= dec_ok;
              err_o <= ~dec_ok;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= ST_RESP;
            cnt   <= '0;
            ack_o <= ok_q;
            err_o <= ~ok_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dat_o = (ack_o && !we_q)
    ? (rd_data & sel_mask(sel_q)) : '0;

endmodule

// File: doc/wishbone_sram_slave.md
# wishbone_sram_slave

Single-port WishBone classic-cycle slave: the responder at the far end of the master/arbiter path. It terminates cycles granted to either master, serving a word-organised on-chip SRAM with byte-lane writes, programmable wait states and an error response for misaligned or out-of-window addresses. It sits behind the two-master arbiter on the shared bus, alongside other slaves decoded by address window.

## Interface
- ADDR_WIDTH, 8, log2 of memory depth in 32-bit words (depth 256)
- BASE_ADDR, 32'h0000_0000, byte base of the slave window; must be aligned to 2^(ADDR_WIDTH+2)
- WAIT_STATES, 0, extra cycles inserted before the response (0..15)

Ports:
- clk_i  in  1  bus clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cyc_i  in  1  bus cycle in progress (from granted master via arbiter)
- stb_i  in  1  strobe; transfer request when cyc_i & stb_i
- we_i   in  1  1 = write, 0 = read
- adr_i  in  32 byte address
- sel_i  in  4  byte-lane selects, bit n = dat bits [8n+7:8n]
- dat_i  in  32 write data
- dat_o  out 32 read data, valid only while ack_o = 1
- ack_o  out 1  normal termination, one-cycle pulse
- err_o  out 1  error termination, one-cycle pulse

## Operation
- FSM states: IDLE, WAIT, RESP. Encoding from package.
- IDLE: on cyc_i & stb_i, latch adr_i, we_i, sel_i, dat_i; check decode; load wait counter with WAIT_STATES; go WAIT if WAIT_STATES > 0, else RESP.
- Decode error: adr_i[1:0] != 0, or adr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2], or sel_i == 4'b0000.
- WAIT: decrement counter each cycle; at 1, go RESP. If cyc_i or stb_i is 0, abort to IDLE: no write, no ack/err.
- RESP: assert exactly one of ack_o (decode OK) or err_o (decode error) for one cycle; go IDLE unconditionally.
- Write commits in the RESP cycle only when decode is OK; only lanes with sel_i = 1 change. Error cycles never modify memory.
- Read: dat_o = word at latched index, lanes with sel = 0 driven 0; dat_o = 0 whenever ack_o = 0.
- Memory index = latched adr[ADDR_WIDTH+1:2]. Memory contents are not reset.
- Back-to-back: a request still asserted in the cycle after RESP is a new transfer, accepted from IDLE.

## Timing
- Reset (async, any state): state IDLE, ack_o = 0, err_o = 0, dat_o = 0, counter = 0; in-flight write discarded.
- Latency: ack_o/err_o is registered and high in cycle N+WAIT_STATES+1 when the request is accepted in cycle N.
- Throughput: one transfer per WAIT_STATES+2 cycles when stb_i is held.
- No combinational path from any input to ack_o, err_o or dat_o.
- Abort: cyc_i low in WAIT returns to IDLE at the next edge. In RESP the response still issues; the master ignores it.
- Counter: 4 bits, no wrap; WAIT_STATES > 15 is a compile-time error.
- Arbiter grant switching after ack_o is safe: the slave is back in IDLE on that edge.

## Structure
- Package wb_pkg: FSM state typedef/constants, WB_DATA_W = 32, WB_SEL_W = 4, WB_ADR_W = 32.
- Sub-module wb_sram_array: 2^ADDR_WIDTH x 32 register array with 4 byte write-enables and a registered read port. Instantiated once; the top holds the FSM, decode, latches and response logic.

## Test plan
- Reset: assert rst_i mid-WAIT with a write pending -> ack_o = 0, err_o = 0, dat_o = 0; a later read of that address returns its pre-write contents.
- WAIT_STATES = 0: write 32'hDEADBEEF at BASE+0x10 with sel = 4'hF -> ack in cycle N+1; read back -> dat_o = 32'hDEADBEEF with ack_o.
- Byte lanes: write 32'h11223344 with sel = 4'b0101 over 32'hFFFFFFFF -> read returns 32'hFF22FF44.
- WAIT_STATES = 3: read accepted in cycle N -> ack_o only in cycle N+4; back-to-back reads -> ack every 5 cycles.
- Errors: adr = BASE+0x2, adr = BASE+(4<<ADDR_WIDTH), and sel = 0 -> err_o pulse, ack_o = 0, memory unchanged.
- Abort: WAIT_STATES = 3, drop cyc_i in the second WAIT cycle -> no ack/err, no write; a new request then completes normally.
